// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Data-memory side of the load/store path. Accepts one load or store per
// transaction from the pipeline, runs a single-outstanding word-addressed bus
// cycle with a req/ack handshake, and returns a lane-aligned, sign/zero
// extended load result or a store completion. A bus that never acknowledges
// within TIMEOUT_CYCLES is reported as an access fault.
//
// Ports
//   clk, resetb            clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready  request handshake; ready only while idle
//   req_we                 1 = store, 0 = load
//   req_be                 byte enables, already lane-positioned
//   req_signed             sign-extend the load result
//   req_addr               effective byte address
//   req_wdata              unshifted store data
//   resp_valid             one-cycle pulse when a transaction finishes
//   resp_rdata             extended load data (0 for stores and faults)
//   resp_err               fault flag, meaningful with resp_valid
//   bus_req                bus request, held until bus_ack
//   bus_we/addr/be/wdata   bus command, stable while bus_req is high
//   bus_ack                bus completes the access this cycle
//   bus_rdata              read data, valid with bus_ack on loads
//   bus_err                bus error, sampled with bus_ack
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t      state;
  logic [15:0] wait_cnt;     // cycles spent in BUSY without an ack
  logic        sign_q;       // latched req_signed for the extraction step
  logic [31:0] result_data;  // staged response, published in RESP
  logic        result_err;

  // Terminal count: the wait counter holds the number of ack-less edges
  // already seen, so the final allowed cycle is TIMEOUT_CYCLES-1.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  // Naturally aligned byte, half-word or word enables are the only shapes
  // that map onto a single bus access.
  function automatic logic be_is_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_is_legal = 1'b1;
      default:                   be_is_legal = 1'b0;
    endcase
  endfunction

  // Replicate store data across every lane so the enabled lanes see the
  // right bytes regardless of the byte offset.
  function automatic logic [31:0] store_lanes(input logic [3:0]  be,
                                              input logic [31:0] wdata);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: store_lanes = {4{wdata[7:0]}};
      4'b0011, 4'b1100:                   store_lanes = {2{wdata[15:0]}};
      default:                            store_lanes = wdata;
    endcase
  endfunction

  // Pick the enabled lane(s) out of the bus word and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [3:0]  be,
                                               input logic [31:0] rdata,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    h = 16'h0000;
    case (be)
      4'b0001: b = rdata[7:0];
      4'b0010: b = rdata[15:8];
      4'b0100: b = rdata[23:16];
      4'b1000: b = rdata[31:24];
      4'b0011: h = rdata[15:0];
      4'b1100: h = rdata[31:16];
      default: ;
    endcase
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        load_extract = {{24{sgn & b[7]}}, b};
      4'b0011, 4'b1100:
        load_extract = {{16{sgn & h[15]}}, h};
      default:
        load_extract = rdata;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register and the
  // result does not depend on statement order.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      // NOTE: every register, including the data-path ones, is reset so an
      // aborted transaction leaves no stale command on the bus outputs.
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      wait_cnt    <= '0;
      sign_q      <= 1'b0;
      result_data <= '0;
      result_err  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;  // pulse: only RESP raises it, for one cycle

      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (be_is_legal(req_be)) begin
              state     <= S_BUSY;
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_be    <= req_be;
              bus_wdata <= store_lanes(req_be, req_wdata);
              sign_q    <= req_signed;
              wait_cnt  <= '0;
            end else begin
              // be==0000 is a decoder-suppressed access and completes
              // cleanly; any other shape is an alignment fault.
              state       <= S_RESP;
              result_data <= '0;
              result_err  <= (req_be != 4'b0000);
            end
          end
        end

        S_BUSY: begin
          // An ack on the terminal cycle still completes the access.
          if (bus_ack) begin
            state       <= S_RESP;
            bus_req     <= 1'b0;
            result_err  <= bus_err;
            result_data <= (bus_err || bus_we) ? '0
                                               : load_extract(bus_be, bus_rdata, sign_q);
          end else if (wait_cnt == LAST_WAIT) begin
            state       <= S_RESP;
            bus_req     <= 1'b0;
            result_err  <= 1'b1;
            result_data <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        S_RESP: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b1;
          resp_rdata <= result_data;
          resp_err   <= result_err;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          bus_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed and randomized transactions against mem_access_unit with a short
// bus timeout. Expected bus commands, handshake timing and response values
// come from a byte-lane arithmetic model of the load/store rules.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        resetb;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int vectors;
  int miscompares;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_be     (req_be),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction, driven and observed on falling edges. Window j is the
  // cycle following rising edge T+j, where T is the acceptance edge.
  // ack_at: window in which bus_ack is raised (<0 or >=TO: never acked).
  task automatic run_txn(input logic        we,
                         input logic [3:0]  be,
                         input logic        sgn,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input int          ack_at,
                         input logic [31:0] rd,
                         input logic        berr,
                         input logic        hold);
    int          nbytes;
    int          off;
    bit          legal;
    bit          tmo;
    int          nreq;
    int          resp_w;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [63:0] v;
    logic [63:0] mask;

    // Model: access size and offset from the enable pattern.
    nbytes = $countones(be);
    off = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) off = i;
    legal = (nbytes == 1 || nbytes == 2 || nbytes == 4) &&
            (off % nbytes == 0) &&
            (be == 4'(((1 << nbytes) - 1) << off));
    tmo = legal && (ack_at < 0 || ack_at >= int'(TO));

    exp_wdata = '0;
    if (legal)
      for (int i = 0; i < 4; i++)
        exp_wdata[8*i +: 8] = wdata[8*(i % nbytes) +: 8];

    if (!legal) begin
      nreq = 0; resp_w = 1; exp_err = (be != 4'b0000); exp_rdata = '0;
    end else if (tmo) begin
      nreq = TO; resp_w = TO + 1; exp_err = 1'b1; exp_rdata = '0;
    end else begin
      nreq = ack_at + 1; resp_w = ack_at + 2; exp_err = berr;
      if (berr || we) exp_rdata = '0;
      else begin
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        v = (64'(rd) >> (8 * off)) & mask;
        if (sgn && v[8*nbytes-1]) v = v | ~mask;
        exp_rdata = v[31:0];
      end
    end

    check("ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_be = be; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int j = 0; j <= resp_w; j++) begin
      @(negedge clk);
      if (!hold || j == resp_w) req_valid = 1'b0;
      else begin
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      bus_ack   = legal && !tmo && (j == ack_at);
      bus_rdata = bus_ack ? rd : $urandom;
      bus_err   = bus_ack ? berr : 1'($urandom);
      check("bus_req", bus_req, legal && (j < nreq));
      if (legal && j < nreq) begin
        check("bus_addr", bus_addr, {addr[31:2], 2'b00});
        check("bus_we", bus_we, we);
        check("bus_be", bus_be, be);
        if (we) check("bus_wdata", bus_wdata, exp_wdata);
      end
      check("req_ready", req_ready, j >= resp_w);
      check("resp_valid", resp_valid, j == resp_w);
      if (j == resp_w) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", resp_err, exp_err);
      end
    end
    @(negedge clk);
    bus_ack = 1'b0;
    check("resp_drop", resp_valid, 1'b0);
    check("ready_after", req_ready, 1'b1);
    check("rdata_hold", resp_rdata, exp_rdata);
    check("err_hold", resp_err, exp_err);
  endtask

  initial begin
    logic [3:0] be_pool [12];
    vectors = 0;
    miscompares = 0;
    be_pool = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100,
                4'b1111, 4'b0000, 4'b0101, 4'b0110, 4'b1001, 4'b0111};

    resetb = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    #12;
    check("rst_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", bus_be, 4'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);

    // LB signed from the top lane.
    run_txn(1'b0, 4'b1000, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h80AA_BBCC, 1'b0, 1'b0);
    check("lb_const", resp_rdata, 32'hFFFF_FF80);
    // LHU / LH on the upper half.
    run_txn(1'b0, 4'b1100, 1'b0, 32'h0000_2002, 32'h0, 1, 32'hBEEF_1234, 1'b0, 1'b0);
    check("lhu_const", resp_rdata, 32'h0000_BEEF);
    run_txn(1'b0, 4'b1100, 1'b1, 32'h0000_2002, 32'h0, 0, 32'hBEEF_1234, 1'b0, 1'b0);
    check("lh_const", resp_rdata, 32'hFFFF_BEEF);
    // SB and SW.
    run_txn(1'b1, 4'b0100, 1'b0, 32'h0000_3006, 32'h1234_56A5, 0, 32'h5555_5555, 1'b0, 1'b0);
    check("sb_rdata", resp_rdata, 32'h0);
    run_txn(1'b1, 4'b1111, 1'b0, 32'h0000_3008, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1'b0);
    // Timeout, and an ack on the terminal cycle.
    run_txn(1'b0, 4'b1111, 1'b0, 32'h0000_4000, 32'h0, -1, 32'h0, 1'b0, 1'b0);
    check("tmo_err", resp_err, 1'b1);
    run_txn(1'b0, 4'b1111, 1'b0, 32'h0000_4004, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b0, 1'b0);
    check("last_ack_data", resp_rdata, 32'hCAFE_F00D);
    // Suppressed, illegal, bus error, held request.
    run_txn(1'b0, 4'b0000, 1'b0, 32'h0000_5001, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    run_txn(1'b1, 4'b0101, 1'b0, 32'h0000_5000, 32'h1111_2222, 0, 32'h0, 1'b0, 1'b0);
    check("illegal_err", resp_err, 1'b1);
    run_txn(1'b0, 4'b0011, 1'b1, 32'h0000_6000, 32'h0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_txn(1'b0, 4'b0001, 1'b1, 32'h0000_7000, 32'h0, 2, 32'h0000_00F0, 1'b0, 1'b1);

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), be_pool[$urandom_range(0, 11)], 1'($urandom), $urandom,
              $urandom, int'($urandom_range(0, 5)) - 1, $urandom,
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset while the bus is waiting.
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'b1111; req_signed = 1'b0;
    req_addr = 32'h0000_8000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_bus_req", bus_req, 1'b1);
    @(negedge clk);
    resetb = 1'b0;
    #1;
    check("arst_bus_req", bus_req, 1'b0);
    check("arst_ready", req_ready, 1'b1);
    check("arst_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    resetb = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_resp", resp_valid, 1'b0);
      check("post_rst_no_req", bus_req, 1'b0);
      check("post_rst_ready", req_ready, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
